// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Registered digit outputs hold steady between conversions for the scan driver.
module bin_to_bcd_seq #(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic [BIN_W-1:0] bin,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [3:0]       d3,
   output logic [3:0]       d2,
   output logic [3:0]       d1,
   output logic [3:0]       d0,
   output logic             ovf
);

   localparam int CW = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [BIN_W-1:0] wbin, wbin_n;
   logic [15:0]      bcd, bcd_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             ovfl, ovfl_n;
   logic [15:0]      digs, digs_n;
   logic             ovf_n;
   logic             busy_n;
   logic             done_n;

   logic [BIN_W-1:0] sat;
   logic             big;
   logic [15:0]      adj;
   logic [BIN_W+15:0] shifted;
   logic             last;

   // Only a 14-bit input can exceed 9999; narrower inputs never saturate.
   generate
      if (BIN_W >= 14) begin : g_cmp
         assign big = (bin > BIN_W'(9999));
         assign sat = big ? BIN_W'(9999) : bin;
      end else begin : g_nocmp
         assign big = 1'b0;
         assign sat = bin;
      end
   endgenerate

   always_comb begin
      adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   assign shifted = {adj, wbin} << 1;
   assign last    = (cnt == CW'(BIN_W - 1));

   always_comb begin
      state_n = state;
      wbin_n  = wbin;
      bcd_n   = bcd;
      cnt_n   = cnt;
      ovfl_n  = ovfl;
      digs_n  = digs;
      ovf_n   = ovf;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = SHIFT;
               wbin_n  = sat;
               bcd_n   = '0;
               cnt_n   = '0;
               ovfl_n  = big;
               busy_n  = 1'b1;
            end
         end
         SHIFT: begin
            bcd_n  = shifted[BIN_W+15:BIN_W];
            wbin_n = shifted[BIN_W-1:0];
            cnt_n  = cnt + 1'b1;
            busy_n = 1'b1;
            // Final iteration: publish the post-shift accumulator directly.
            if (last) begin
               state_n = DONE;
               digs_n  = shifted[BIN_W+15:BIN_W];
               ovf_n   = ovfl;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state <= IDLE;
         wbin  <= '0;
         bcd   <= '0;
         cnt   <= '0;
         ovfl  <= 1'b0;
         digs  <= '0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         wbin  <= wbin_n;
         bcd   <= bcd_n;
         cnt   <= cnt_n;
         ovfl  <= ovfl_n;
         digs  <= digs_n;
         ovf   <= ovf_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   assign d3 = digs[15:12];
   assign d2 = digs[11:8];
   assign d1 = digs[7:4];
   assign d0 = digs[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W = 14).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rstN;
   logic [13:0] bin;
   logic        start;
   logic        busy;
   logic        done;
   logic [3:0]  d3, d2, d1, d0;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   bin_to_bcd_seq #(.BIN_W(14)) dut (
      .clk   (clk),
      .rstN  (rstN),
      .bin   (bin),
      .start (start),
      .busy  (busy),
      .done  (done),
      .d3    (d3),
      .d2    (d2),
      .d1    (d1),
      .d0    (d0),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] digs();
      return {d3, d2, d1, d0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle with value v and watch 30 cycles.
   task automatic run_conv(input logic [13:0] v,
                           output int lat, output int nbusy,
                           output int ndone, output int nboth,
                           output logic [15:0] res, output logic rovf);
      lat = 0; nbusy = 0; ndone = 0; nboth = 0;
      res = 16'hxxxx; rovf = 1'bx;
      bin = v;
      start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (k == 1) begin
            start = 1'b0;
            bin = ~v;
         end
         if (busy) nbusy++;
         if (busy && done) nboth++;
         if (done) begin
            ndone++;
            if (lat == 0) begin
               lat = k;
               res = digs();
               rovf = ovf;
            end
         end
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0; start = 1'b0; bin = 14'd1234;
      tick(); tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
      end
      checks++;
      if (digs() !== 16'h0000 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_digits got=%h ovf=%b required 0000 0", digs(), ovf);
      end
      rstN = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int lat, nb, nd, nboth;
      logic [15:0] r;
      logic o;
      run_conv(14'd1234, lat, nb, nd, nboth, r, o);
      checks++;
      if (lat !== 15) begin
         errors++;
         $display("FAIL basic_latency got=%0d required 15", lat);
      end
      checks++;
      if (nb !== 14) begin
         errors++;
         $display("FAIL basic_busy_cycles got=%0d required 14", nb);
      end
      checks++;
      if (nd !== 1 || nboth !== 0) begin
         errors++;
         $display("FAIL basic_done_pulses got=%0d overlap=%0d required 1 0", nd, nboth);
      end
      checks++;
      if (r !== 16'h1234 || o !== 1'b0) begin
         errors++;
         $display("FAIL basic_value got=%h ovf=%b required 1234 0", r, o);
      end
      checks++;
      if (digs() !== 16'h1234) begin
         errors++;
         $display("FAIL basic_hold got=%h required 1234", digs());
      end
   endtask

   task automatic test_boundaries();
      logic [13:0] vin [4] = '{14'd0, 14'd9, 14'd10, 14'd9999};
      logic [15:0] vexp [4] = '{16'h0000, 16'h0009, 16'h0010, 16'h9999};
      int lat, nb, nd, nboth;
      logic [15:0] r;
      logic o;
      for (int i = 0; i < 4; i++) begin
         run_conv(vin[i], lat, nb, nd, nboth, r, o);
         checks++;
         if (nd !== 1 || r !== vexp[i] || o !== 1'b0) begin
            errors++;
            $display("FAIL boundary_%0d got=%h ovf=%b done=%0d required %h 0 1",
                     vin[i], r, o, nd, vexp[i]);
         end
      end
   endtask

   task automatic test_saturation();
      int lat, nb, nd, nboth;
      logic [15:0] r;
      logic o;
      run_conv(14'd12000, lat, nb, nd, nboth, r, o);
      checks++;
      if (r !== 16'h9999 || o !== 1'b1) begin
         errors++;
         $display("FAIL sat_12000 got=%h ovf=%b required 9999 1", r, o);
      end
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL sat_ovf_hold got=%b required 1", ovf);
      end
      run_conv(14'd42, lat, nb, nd, nboth, r, o);
      checks++;
      if (r !== 16'h0042 || o !== 1'b0) begin
         errors++;
         $display("FAIL sat_clear got=%h ovf=%b required 0042 0", r, o);
      end
   endtask

   task automatic test_busy_reject();
      int lat, nb, nd, nboth, nd2, bad;
      logic [15:0] r;
      logic o;
      run_conv(14'd1234, lat, nb, nd, nboth, r, o);
      nd2 = 0; bad = 0; r = 16'hxxxx;
      bin = 14'd5678;
      start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         start = (k == 5);
         if (k == 1 || k == 5) bin = 14'd1111;
         if (done) begin
            nd2++;
            if (nd2 == 1) r = digs();
         end else if (nd2 == 0 && digs() !== 16'h1234) begin
            bad++;
         end
      end
      checks++;
      if (nd2 !== 1) begin
         errors++;
         $display("FAIL reject_done_pulses got=%0d required 1", nd2);
      end
      checks++;
      if (r !== 16'h5678) begin
         errors++;
         $display("FAIL reject_value got=%h required 5678", r);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reject_hold unstable_cycles=%0d required 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      int lat, nb, nd, nboth, nd2, bad;
      logic [15:0] r;
      logic o;
      nd2 = 0; bad = 0;
      bin = 14'd4321;
      start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         start = 1'b0;
         if (k == 7) rstN = 1'b0;
         if (k == 8) begin
            rstN = 1'b1;
            checks++;
            if (busy !== 1'b0 || digs() !== 16'h0000 || ovf !== 1'b0) begin
               errors++;
               $display("FAIL midreset_state busy=%b got=%h ovf=%b required 0 0000 0",
                        busy, digs(), ovf);
            end
         end
         if (done) nd2++;
         if (k >= 8 && (busy || digs() !== 16'h0000)) bad++;
      end
      checks++;
      if (nd2 !== 0 || bad !== 0) begin
         errors++;
         $display("FAIL midreset_quiet done=%0d bad=%0d required 0 0", nd2, bad);
      end
      run_conv(14'd4321, lat, nb, nd, nboth, r, o);
      checks++;
      if (r !== 16'h4321 || nd !== 1) begin
         errors++;
         $display("FAIL midreset_restart got=%h done=%0d required 4321 1", r, nd);
      end
   endtask

   task automatic test_back_to_back();
      int nd, first, prev, badgap, badnib, nboth, badval;
      nd = 0; first = 0; prev = 0; badgap = 0; badnib = 0;
      nboth = 0; badval = 0;
      bin = 14'd77;
      start = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (d3 > 4'd9 || d2 > 4'd9 || d1 > 4'd9 || d0 > 4'd9) badnib++;
         if (busy && done) nboth++;
         if (done) begin
            nd++;
            if (digs() !== 16'h0077) badval++;
            if (first == 0) first = k;
            else if (k - prev != 16) badgap++;
            prev = k;
         end
      end
      start = 1'b0;
      checks++;
      if (first !== 15 || nd !== 4) begin
         errors++;
         $display("FAIL b2b_pulses first=%0d count=%0d required 15 4", first, nd);
      end
      checks++;
      if (badgap !== 0) begin
         errors++;
         $display("FAIL b2b_spacing bad_gaps=%0d required 0", badgap);
      end
      checks++;
      if (badval !== 0 || digs() !== 16'h0077) begin
         errors++;
         $display("FAIL b2b_value got=%h bad=%0d required 0077 0", digs(), badval);
      end
      checks++;
      if (badnib !== 0 || nboth !== 0) begin
         errors++;
         $display("FAIL b2b_range bad_nibbles=%0d overlap=%0d required 0 0",
                  badnib, nboth);
      end
   endtask

   initial begin
      rstN = 1'b0;
      start = 1'b0;
      bin = '0;
      test_reset();
      test_basic();
      test_boundaries();
      test_saturation();
      test_busy_reject();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
